// File: rtl/ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl_if.sv
// Signal bundle between the PHY sequencer/PLL and the PLL dynamic phase-shift controller.
// The controller uses the slave modport; whoever drives requests and models the PLL uses master.
interface ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl_if #(
    parameter int unsigned STEP_W = 6
);
    logic              req;
    logic [3:0]        req_counter;
    logic              req_updown;
    logic [STEP_W-1:0] req_num_steps;
    logic              pll_locked;
    logic              pll_phasedone;
    logic [3:0]        pll_phasecounterselect;
    logic              pll_phasestep;
    logic              pll_phaseupdown;
    logic              busy;
    logic              ack;
    logic              err;
    logic [STEP_W-1:0] steps_done;

    modport master (
        output req, req_counter, req_updown, req_num_steps, pll_locked, pll_phasedone,
        input  pll_phasecounterselect, pll_phasestep, pll_phaseupdown, busy, ack, err,
               steps_done
    );

    modport slave (
        input  req, req_counter, req_updown, req_num_steps, pll_locked, pll_phasedone,
        output pll_phasecounterselect, pll_phasestep, pll_phaseupdown, busy, ack, err,
               steps_done
    );
endinterface

// File: rtl/ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl.sv
// PLL dynamic phase-shift controller: steps one PLL counter N times, pacing each step on
// phasedone, with timeout and lock-loss abort. Single scan_clk domain, all outputs registered.
module ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl #(
    parameter int unsigned STEP_W    = 6,
    parameter int unsigned STEP_HOLD = 2,
    parameter int unsigned TIMEOUT   = 63
) (
    input logic scan_clk,
    input logic reset_scan_clk_n,
    ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl_if.slave bus
);
    localparam int unsigned HOLD_W = (STEP_HOLD > 1) ? $clog2(STEP_HOLD) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STEP_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StStep, StWaitLo, StWaitHi, StGap, StDone
    } state_e;

    state_e            state_q;
    logic [STEP_W-1:0] remaining_q;
    logic [HOLD_W-1:0] hold_q;
    logic [TO_W-1:0]   wait_q;
    logic              abort_q;
    logic              lock_lost;

    assign lock_lost = !bus.pll_locked && (state_q != StIdle) && (state_q != StDone);

    always_ff @(posedge scan_clk or negedge reset_scan_clk_n) begin
        if (!reset_scan_clk_n) begin
            state_q                    <= StIdle;
            remaining_q                <= '0;
            hold_q                     <= '0;
            wait_q                     <= '0;
            abort_q                    <= 1'b0;
            bus.pll_phasecounterselect <= '0;
            bus.pll_phasestep          <= 1'b0;
            bus.pll_phaseupdown        <= 1'b0;
            bus.busy                   <= 1'b0;
            bus.ack                    <= 1'b0;
            bus.err                    <= 1'b0;
            bus.steps_done             <= '0;
        end else begin
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.req && bus.pll_locked) begin
                        bus.pll_phasecounterselect <= bus.req_counter;
                        bus.pll_phaseupdown        <= bus.req_updown;
                        remaining_q                <= bus.req_num_steps;
                        bus.steps_done             <= '0;
                        bus.busy                   <= 1'b1;
                        abort_q                    <= 1'b0;
                        state_q                    <= StSetup;
                    end
                end
                StSetup: begin
                    if (remaining_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        bus.pll_phasestep <= 1'b1;
                        hold_q            <= '0;
                        state_q           <= StStep;
                    end
                end
                StStep: begin
                    if (hold_q == HOLD_LAST) begin
                        bus.pll_phasestep <= 1'b0;
                        wait_q            <= '0;
                        state_q           <= StWaitLo;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                // wait_q counts every cycle spent in WAIT_LO and WAIT_HI together
                StWaitLo: begin
                    if (wait_q == TO_LAST) begin
                        abort_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                        if (!bus.pll_phasedone) state_q <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (bus.pll_phasedone) begin
                        if (bus.steps_done != '1) bus.steps_done <= bus.steps_done + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        state_q     <= StGap;
                    end else if (wait_q == TO_LAST) begin
                        abort_q <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StGap: begin
                    if (remaining_q != '0) begin
                        bus.pll_phasestep <= 1'b1;
                        hold_q            <= '0;
                        state_q           <= StStep;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    bus.ack  <= 1'b1;
                    bus.err  <= abort_q;
                    bus.busy <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Lock loss overrides whatever the state decided this cycle
            if (lock_lost) begin
                bus.pll_phasestep <= 1'b0;
                abort_q           <= 1'b1;
                state_q           <= StDone;
            end
        end
    end
endmodule

// File: doc/ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl.md
# ddr3_s4_amphy_phy_alt_mem_phy_pll_phs_ctrl

Dynamic phase-shift controller for the DDR3 PHY PLL. It accepts "shift counter X by N steps up or down" requests from the PHY sequencer and drives the PLL's `phasecounterselect` / `phasestep` / `phaseupdown` inputs. It paces each step on the PLL's `phasedone` handshake and reports completion, step count, and timeout or lock-loss errors. It runs entirely in the PLL scan-clock domain.

## Interface
Parameters:
- `STEP_W`, 6: width of the step-count request and the progress counter.
- `STEP_HOLD`, 2: `scan_clk` cycles `pll_phasestep` is held high per step (legal range ≥ 2).
- `TIMEOUT`, 63: maximum `scan_clk` cycles allowed between `pll_phasestep` falling and `phasedone` returning high.

Ports:
- `scan_clk` in, 1: PLL scan clock; only clock.
- `reset_scan_clk_n` in, 1: asynchronous, active-low reset.
- `req` in, 1: request strobe; sampled only in IDLE.
- `req_counter` in, 4: PLL counter select.
- `req_updown` in, 1: 1 = shift up (later), 0 = shift down.
- `req_num_steps` in, `STEP_W`: number of steps.
- `pll_locked` in, 1: PLL lock.
- `pll_phasedone` in, 1: PLL phase-done; low while a step is in progress.
- `pll_phasecounterselect` out, 4: to PLL.
- `pll_phasestep` out, 1: to PLL.
- `pll_phaseupdown` out, 1: to PLL.
- `busy` out, 1: request in progress.
- `ack` out, 1: one-cycle completion pulse.
- `err` out, 1: valid with `ack`; 1 = aborted.
- `steps_done` out, `STEP_W`: steps completed in the current or last request.

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states: IDLE, SETUP, STEP, WAIT_LO, WAIT_HI, GAP, DONE.
- IDLE:
  - Exit condition: `req`=1 and `pll_locked`=1.
  - On exit, latch `req_counter` into `pll_phasecounterselect`, `req_updown` into `pll_phaseupdown`, and `req_num_steps` into the remaining-step counter.
  - Clear `steps_done` and set `busy`.
  - `req` while `pll_locked`=0 is ignored, with no ack.
- SETUP: lasts one cycle so select/updown are stable before the step. Next state is DONE (err=0) if remaining = 0, else STEP.
- STEP: `pll_phasestep`=1 for exactly `STEP_HOLD` cycles, then WAIT_LO.
- WAIT_LO: wait for `pll_phasedone`=0, then WAIT_HI.
- WAIT_HI: wait for `pll_phasedone`=1. On exit, increment `steps_done` and decrement remaining, then go to GAP.
- GAP: lasts one cycle, then STEP if remaining ≠ 0, else DONE.
- Timeout:
  - The cycle counter is cleared on entry to WAIT_LO and counts in WAIT_LO and WAIT_HI.
  - Reaching `TIMEOUT` goes to DONE with err=1.
- Lock loss: `pll_locked`=0 in any state other than IDLE or DONE goes to DONE with err=1. `pll_phasestep` is forced low from the next cycle.
- DONE: lasts one cycle.
  - `ack`=1, and `err` as determined above.
  - `busy` drops on the same edge that raises `ack`.
  - Next state is IDLE.
- `pll_phasecounterselect` and `pll_phaseupdown` hold their values from SETUP until the next accepted request. They never change while `busy`=1.
- `steps_done` holds its final value after DONE until the next accept. It saturates at all-ones (cannot overflow because remaining ≤ max).
- Reset mid-operation: all outputs go to 0 immediately (asynchronous), including `pll_phasestep`. The FSM returns to IDLE.

## Timing
- Accept on edge T:
  - `busy`=1 after T.
  - `pll_phasestep` rises after T+1 and falls after T+1+`STEP_HOLD`.
- Per-step minimum: `STEP_HOLD` + 1 (WAIT_LO) + 1 (WAIT_HI) + 1 (GAP) cycles, plus the PLL's own `phasedone` latency.
- N=0 request: `ack` after T+2, `busy` is high for 2 cycles, no `pll_phasestep`.
- Back-to-back requests: the earliest next accept is the cycle after `ack` (the IDLE cycle).
- `pll_phasedone` is used directly, with no synchronizer (same clock domain). A `pll_phasedone` low already present during STEP is ignored until WAIT_LO.

## Test plan
- Reset, then counter 2, up, 3 steps, with a PLL model that drops `phasedone` 2 cycles after `phasestep` falls and keeps it low 4 cycles:
  - Exactly three 2-cycle `pll_phasestep` pulses.
  - `pll_phasecounterselect`=2 and `pll_phaseupdown`=1 stable throughout.
  - `ack`=1, `err`=0, `steps_done`=3.
- `req_num_steps`=0: `ack` 2 cycles after accept, no `pll_phasestep`, `steps_done`=0.
- Model never drops `phasedone`: `ack`/`err`=1 at `TIMEOUT` cycles after the first step, `steps_done`=0.
- Deassert `pll_locked` during the 2nd step of 5:
  - `pll_phasestep` low the next cycle.
  - `ack`/`err`=1, `steps_done`=1.
  - `req` while unlocked: no response.
- Assert `reset_scan_clk_n`=0 while `pll_phasestep`=1: all outputs go to 0 asynchronously. A new request after release completes normally.
- Two requests:
  - `req` held high during `busy` is ignored.
  - A second request (counter 5, down, 1 step) issued the cycle after `ack` is accepted with the new select/updown values.
